// File: rtl/debug_dump_tx.sv
// Streams a debug snapshot (PC, cycle count, register file, data memory) out
// through a byte-wide UART transmitter, most significant byte of each word first.
module debug_dump_tx #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_TRAMA    = 8,
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 32,
  parameter int MEM_ADDR_BITS = $clog2(NUM_MEM_WORDS),
  parameter int REG_ADDR_BITS = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [BITS_SIZE-1:0]     i_pc,
  input  logic [BITS_SIZE-1:0]     i_clk_count,
  input  logic [BITS_SIZE-1:0]     i_reg_data,
  input  logic [BITS_SIZE-1:0]     i_mem_data,
  input  logic                     i_uart_tx_done,
  output logic [REG_ADDR_BITS-1:0] o_select_reg_dir,
  output logic [MEM_ADDR_BITS-1:0] o_select_mem_dir,
  output logic                     o_uart_tx_start,
  output logic [SIZE_TRAMA-1:0]    o_uart_tx_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int TOTAL_WORDS = NUM_REGS + NUM_MEM_WORDS + 2;
  localparam int WIDX        = $clog2(TOTAL_WORDS);
  localparam int BYTES       = BITS_SIZE / SIZE_TRAMA;
  localparam int BIDX        = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [WIDX-1:0] FIRST_REG = WIDX'(2);
  localparam logic [WIDX-1:0] FIRST_MEM = WIDX'(NUM_REGS + 2);
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(TOTAL_WORDS - 1);
  localparam logic [BIDX-1:0] LAST_BYTE = BIDX'(BYTES - 1);

  typedef enum logic [2:0] {IDLE, SELECT, LATCH, SEND, WAIT, DONE} state_e;

  state_e                   state_q, state_d;
  logic [WIDX-1:0]          word_idx_q, word_idx_d;
  logic [BIDX-1:0]          byte_idx_q, byte_idx_d;
  logic [BITS_SIZE-1:0]     pc_snap_q, pc_snap_d;
  logic [BITS_SIZE-1:0]     cnt_snap_q, cnt_snap_d;
  logic [BITS_SIZE-1:0]     shift_q, shift_d;
  logic [SIZE_TRAMA-1:0]    tx_data_q, tx_data_d;
  logic [REG_ADDR_BITS-1:0] sel_reg_q, sel_reg_d;
  logic [MEM_ADDR_BITS-1:0] sel_mem_q, sel_mem_d;
  logic [BITS_SIZE-1:0]     word_mux;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      pc_snap_q  <= '0;
      cnt_snap_q <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      sel_reg_q  <= '0;
      sel_mem_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      pc_snap_q  <= pc_snap_d;
      cnt_snap_q <= cnt_snap_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
      sel_reg_q  <= sel_reg_d;
      sel_mem_q  <= sel_mem_d;
    end
  end

  always_comb begin
    word_mux = i_mem_data;
    if (word_idx_q == '0)            word_mux = pc_snap_q;
    else if (word_idx_q == WIDX'(1)) word_mux = cnt_snap_q;
    else if (word_idx_q < FIRST_MEM) word_mux = i_reg_data;
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    pc_snap_d  = pc_snap_q;
    cnt_snap_d = cnt_snap_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
    sel_reg_d  = sel_reg_q;
    sel_mem_d  = sel_mem_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          pc_snap_d  = i_pc;
          cnt_snap_d = i_clk_count;
          word_idx_d = '0;
          byte_idx_d = '0;
          state_d    = SELECT;
        end
      end
      SELECT: state_d = LATCH;
      LATCH: begin
        // The outgoing byte is registered here so it stays put until the next SEND.
        tx_data_d  = word_mux[BITS_SIZE-1 -: SIZE_TRAMA];
        shift_d    = word_mux << SIZE_TRAMA;
        byte_idx_d = '0;
        state_d    = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (i_uart_tx_done) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + BIDX'(1);
            tx_data_d  = shift_q[BITS_SIZE-1 -: SIZE_TRAMA];
            shift_d    = shift_q << SIZE_TRAMA;
            state_d    = SEND;
          end else if (word_idx_q != LAST_WORD) begin
            word_idx_d = word_idx_q + WIDX'(1);
            state_d    = SELECT;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Selects are registered on entry to SELECT so the storage sees them for a full cycle.
    if (state_d == SELECT) begin
      if (word_idx_d >= FIRST_REG && word_idx_d < FIRST_MEM) begin
        sel_reg_d = REG_ADDR_BITS'(word_idx_d - FIRST_REG);
      end else if (word_idx_d >= FIRST_MEM) begin
        sel_mem_d = MEM_ADDR_BITS'(word_idx_d - FIRST_MEM);
      end
    end
  end

  assign o_select_reg_dir = sel_reg_q;
  assign o_select_mem_dir = sel_mem_q;
  assign o_uart_tx_start  = (state_q == SEND);
  assign o_uart_tx_data   = tx_data_q;
  assign o_busy           = (state_q != IDLE);
  assign o_done           = (state_q == DONE);

endmodule

// File: doc/debug_dump_tx.md
DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

Interface
REQ-001 Parameter BITS_SIZE, default 32, width of every dumped word.
REQ-002 Parameter SIZE_TRAMA, default 8, UART frame width.
REQ-003 Parameter NUM_REGS, default 32, register-file words dumped.
REQ-004 Parameter NUM_MEM_WORDS, default 32, data-memory words dumped; MEM_ADDR_BITS = clog2(NUM_MEM_WORDS), REG_ADDR_BITS = clog2(NUM_REGS).
REQ-005 i_clk  input  1  single clock; all logic on posedge.
REQ-006 i_reset  input  1  reset; synchronous, active-high.
REQ-007 i_start  input  1  dump request, sampled in IDLE only.
REQ-008 i_pc  input  BITS_SIZE  current MIPS PC.
REQ-009 i_clk_count  input  BITS_SIZE  executed-cycle counter.
REQ-010 i_reg_data  input  BITS_SIZE  register-file word at o_select_reg_dir, valid one cycle after select.
REQ-011 i_mem_data  input  BITS_SIZE  data-memory word at o_select_mem_dir, valid one cycle after select.
REQ-012 i_uart_tx_done  input  1  one-cycle pulse, UART finished current frame.
REQ-013 o_select_reg_dir  output  REG_ADDR_BITS  register read index.
REQ-014 o_select_mem_dir  output  MEM_ADDR_BITS  data-memory word index.
REQ-015 o_uart_tx_start  output  1  one-cycle pulse, launch frame.
REQ-016 o_uart_tx_data  output  SIZE_TRAMA  byte to transmit.
REQ-017 o_busy  output  1  high from first cycle after accepted i_start until DONE exits.
REQ-018 o_done  output  1  one-cycle pulse at end of dump.

Function
REQ-019 FSM states SHALL be IDLE, SELECT, LATCH, SEND, WAIT, DONE.
REQ-020 IDLE: i_start=1 -> snapshot i_pc and i_clk_count into internal registers, word_idx=0, go SELECT.
REQ-021 Word order SHALL be: word 0 = PC snapshot, word 1 = clk_count snapshot, words 2..NUM_REGS+1 = registers 0..NUM_REGS-1, then NUM_MEM_WORDS memory words 0..N-1; default total 66 words = 264 bytes.
REQ-022 SELECT (1 cycle): o_select_reg_dir = word_idx-2 while in register range, o_select_mem_dir = word_idx-NUM_REGS-2 while in memory range; selects hold their last value otherwise.
REQ-023 LATCH (1 cycle): capture selected word (snapshot, i_reg_data or i_mem_data) into shift register, byte_idx=0, go SEND.
REQ-024 SEND (1 cycle): o_uart_tx_start=1, o_uart_tx_data = byte byte_idx, MSB byte first; go WAIT.
REQ-025 o_uart_tx_data SHALL stay stable from SEND until the next SEND.
REQ-026 WAIT: hold until i_uart_tx_done=1; then byte_idx<3 -> byte_idx+1, SEND; byte_idx=3 and not last word -> word_idx+1, SELECT; last word -> DONE.
REQ-027 i_uart_tx_done outside WAIT SHALL be ignored, including a pulse in the SEND cycle.
REQ-028 DONE (1 cycle): o_done=1, o_busy=0 next cycle, return IDLE.
REQ-029 i_start while not in IDLE SHALL be ignored; i_start held high through DONE starts a new dump only on the IDLE cycle after DONE.
REQ-030 Latency: i_start in cycle 0 -> SELECT cycle 1, LATCH cycle 2, first o_uart_tx_start cycle 3; byte-to-byte gap after tx_done = 1 cycle within word, 3 cycles across words.
REQ-031 Register/memory values SHALL be read live (not snapshotted); PC and clk_count SHALL be the snapshots taken at start.

Reset
REQ-032 i_reset=1 at any edge SHALL force IDLE, o_uart_tx_start=0, o_uart_tx_data=0, o_busy=0, o_done=0, selects=0, word_idx=byte_idx=0, snapshots=0.
REQ-033 Reset mid-dump SHALL abort with no further o_uart_tx_start; reset has priority over i_start in the same cycle.

Verification
REQ-034 Reset for 2 cycles -> all outputs 0, state IDLE, no tx_start for 20 idle cycles.
REQ-035 i_pc=0x00400010, i_clk_count=0x0000002A, regs r[k]=k, mem m[k]=0xA0000000+k, tx_done 5 cycles after each start -> 264 tx_start pulses, bytes begin 00 40 00 10 00 00 00 2A 00 00 00 00, final byte 0x1F, exactly one o_done.
REQ-036 tx_done withheld 100 cycles -> no new tx_start, o_uart_tx_data unchanged, o_busy=1.
REQ-037 i_start pulsed during byte 7 and tx_done pulsed during SEND -> both ignored, byte count still 264.
REQ-038 Reset asserted after byte 50 -> next-cycle outputs all 0; new i_start then yields first byte 0x00 of PC snapshot taken at the new start.
REQ-039 First-start latency check: i_start in cycle 0 -> o_uart_tx_start exactly in cycle 3, o_busy high from cycle 1.
